// File: rtl/sp_ram_pkg.sv
// Shared constants and lane helpers for the single-port RAM and its read pipeline.
// Helpers work on MAX_W-wide words; callers size-cast arguments and results.
package sp_ram_pkg;

  localparam int WR_RSP_NONE = 0;
  localparam int WR_RSP_THRU = 1;
  localparam int MAX_W       = 256;
  localparam int MAX_NB      = 32;

  function automatic int nb(input int width, input int byte_w);
    return width / byte_w;
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0]  old_w,
                                                  input logic [MAX_W-1:0]  new_w,
                                                  input logic [MAX_NB-1:0] be,
                                                  input int                byte_w);
    logic [MAX_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_W; i++) begin
      if ((i / byte_w) < MAX_NB && be[i / byte_w]) res[i] = new_w[i];
    end
    return res;
  endfunction

  // Even parity: the returned bit makes each lane plus its parity bit XOR to zero.
  function automatic logic [MAX_NB-1:0] lane_parity(input logic [MAX_W-1:0] word,
                                                    input int               byte_w);
    logic [MAX_NB-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if ((i / byte_w) < MAX_NB) p[i / byte_w] = p[i / byte_w] ^ word[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/sp_ram_pipe_if.sv
// Request/response bus of sp_ram_pipe; parity_err is present only with SP_RAM_PARITY_EN.
interface sp_ram_pipe_if
  import sp_ram_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int BYTE_W = 8
);
  localparam int NB = nb(WIDTH, BYTE_W);
  localparam int AW = addr_w(DEPTH);

  logic             en;
  logic             wen;
  logic [NB-1:0]    be;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
`ifdef SP_RAM_PARITY_EN
  logic [NB-1:0]    parity_err;
`endif

  modport master (
    output en, output wen, output be, output addr, output din,
    input  dout, input dout_vld
`ifdef SP_RAM_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  en, input wen, input be, input addr, input din,
    output dout, output dout_vld
`ifdef SP_RAM_PARITY_EN
    , output parity_err
`endif
  );

endinterface

// File: rtl/sp_ram_rd_pipe.sv
// {vld,data} delay line of LAT stages; data registers load only behind a valid bit.
// Synchronous active-high reset clears valid bits and zeroes data so the output idles at 0.
module sp_ram_rd_pipe #(
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld_i,
  input  logic [DW-1:0] dat_i,
  output logic          vld_o,
  output logic [DW-1:0] dat_o
);

  logic [LAT-1:0] vld_q;
  logic [DW-1:0]  dat_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      if (vld_i) dat_q[0] <= dat_i;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[LAT-1];
  assign dat_o = dat_q[LAT-1];

endmodule

// File: rtl/sp_ram_pipe.sv
// Single-port RAM with byte enables, RD_LAT-cycle read pipeline and optional write-through response.
// Optional per-lane even parity when SP_RAM_PARITY_EN is defined (adds parity_err to the bus).
module sp_ram_pipe
  import sp_ram_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int BYTE_W = 8,
  parameter int RD_LAT = 1,
  parameter int WR_RSP = WR_RSP_NONE
) (
  input  logic         clk,
  input  logic         rst,
  sp_ram_pipe_if.slave bus
);

  localparam int NB = nb(WIDTH, BYTE_W);
`ifdef SP_RAM_PARITY_EN
  localparam int MW = WIDTH + NB;
  localparam int PW = WIDTH + NB;
`else
  localparam int MW = WIDTH;
  localparam int PW = WIDTH;
`endif

  if ((WIDTH % BYTE_W) != 0 || RD_LAT < 1 || RD_LAT > 4 ||
      WIDTH > MAX_W || NB > MAX_NB) begin : g_bad_param
    $fatal(1, "sp_ram_pipe: illegal WIDTH/BYTE_W/RD_LAT combination");
  end

  logic [MW-1:0]    mem_q [DEPTH];
  logic [MW-1:0]    mem_d;
  logic [MW-1:0]    rd_word;
  logic             in_rng;
  logic             wr_go;
  logic             pipe_vld_d;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] rsp_dat;
  logic [PW-1:0]    pipe_dat_d;
  logic [PW-1:0]    pipe_dat;
  logic             pipe_vld;
`ifdef SP_RAM_PARITY_EN
  logic [NB-1:0]    new_par;
  logic [NB-1:0]    old_par;
  logic [NB-1:0]    rd_err;
`endif

  always_comb begin
    in_rng     = 32'(bus.addr) < DEPTH;
    rd_word    = in_rng ? mem_q[bus.addr] : '0;
    merged     = WIDTH'(byte_merge(MAX_W'(rd_word[WIDTH-1:0]), MAX_W'(bus.din),
                                   MAX_NB'(bus.be), BYTE_W));
    wr_go      = !rst && bus.en && bus.wen && in_rng;
    pipe_vld_d = !rst && bus.en && (!bus.wen || WR_RSP == WR_RSP_THRU);
    // Out-of-range accesses answer with zero data, for reads and write-through alike.
    rsp_dat    = !in_rng ? '0 : (bus.wen ? merged : rd_word[WIDTH-1:0]);
`ifdef SP_RAM_PARITY_EN
    new_par    = NB'(lane_parity(MAX_W'(bus.din), BYTE_W));
    old_par    = rd_word[MW-1:WIDTH];
    mem_d      = {(new_par & bus.be) | (old_par & ~bus.be), merged};
    rd_err     = (bus.wen || !in_rng) ? '0
               : (NB'(lane_parity(MAX_W'(rd_word[WIDTH-1:0]), BYTE_W)) ^ old_par);
    pipe_dat_d = {rd_err, rsp_dat};
`else
    mem_d      = merged;
    pipe_dat_d = rsp_dat;
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_go) mem_q[bus.addr] <= mem_d;
  end

  sp_ram_rd_pipe #(
    .DW  (PW),
    .LAT (RD_LAT)
  ) u_rd_pipe (
    .clk   (clk),
    .rst   (rst),
    .vld_i (pipe_vld_d),
    .dat_i (pipe_dat_d),
    .vld_o (pipe_vld),
    .dat_o (pipe_dat)
  );

  assign bus.dout     = pipe_dat[WIDTH-1:0];
  assign bus.dout_vld = pipe_vld;
`ifdef SP_RAM_PARITY_EN
  assign bus.parity_err = pipe_dat[PW-1:WIDTH];
`endif

endmodule

// File: tb/tb_sp_ram_pipe.sv
// Drives three RAM configurations with one shared stimulus stream and checks each against
// a cycle-indexed response timeline model; directed steps first, then random traffic.
module tb_sp_ram_pipe;
  import sp_ram_pkg::*;

  localparam int NE = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;
  logic        wen;
  logic [3:0]  be;
  logic [3:0]  addr;
  logic [31:0] din;

  int n_chk = 0;
  int n_fail = 0;
  int e = 0;

  sp_ram_pipe_if #(.WIDTH(32), .DEPTH(16), .BYTE_W(8)) ia ();
  sp_ram_pipe_if #(.WIDTH(32), .DEPTH(10), .BYTE_W(8)) ib ();
  sp_ram_pipe_if #(.WIDTH(32), .DEPTH(16), .BYTE_W(8)) ic ();

  sp_ram_pipe #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .RD_LAT(1), .WR_RSP(WR_RSP_NONE))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  sp_ram_pipe #(.WIDTH(32), .DEPTH(10), .BYTE_W(8), .RD_LAT(2), .WR_RSP(WR_RSP_THRU))
    dut_b (.clk(clk), .rst(rst), .bus(ib));
  sp_ram_pipe #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .RD_LAT(3), .WR_RSP(WR_RSP_NONE))
    dut_c (.clk(clk), .rst(rst), .bus(ic));

  assign ia.en = en;  assign ia.wen = wen;  assign ia.be = be;  assign ia.addr = addr;  assign ia.din = din;
  assign ib.en = en;  assign ib.wen = wen;  assign ib.be = be;  assign ib.addr = addr;  assign ib.din = din;
  assign ic.en = en;  assign ic.wen = wen;  assign ic.be = be;  assign ic.addr = addr;  assign ic.din = din;

  logic        obs_vld [3];
  logic [31:0] obs_dat [3];
  assign obs_vld[0] = ia.dout_vld;  assign obs_dat[0] = ia.dout;
  assign obs_vld[1] = ib.dout_vld;  assign obs_dat[1] = ib.dout;
  assign obs_vld[2] = ic.dout_vld;  assign obs_dat[2] = ic.dout;

  // Reference model: memory image plus, per edge, the response that edge's request will produce.
  logic [31:0] mm      [3][16];
  bit          rv      [3][NE];
  logic [31:0] rd      [3][NE];
  logic        exp_vld [3];
  logic [31:0] exp_dat [3];

  function automatic int lat_of(int k);  return k + 1;              endfunction
  function automatic int dep_of(int k);  return (k == 1) ? 10 : 16; endfunction
  function automatic bit thru_of(int k); return k == 1;             endfunction

  function automatic logic [31:0] tb_merge(logic [31:0] o, logic [31:0] n, logic [3:0] b);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (b[i]) m = m | (32'hFF << (8 * i));
    return (o & ~m) | (n & m);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic model_edge(input int k);
    int          lat;
    int          idx;
    bit          inr;
    logic [31:0] old;
    logic [31:0] mg;
    lat = lat_of(k);
    rv[k][e] = 1'b0;
    rd[k][e] = 32'h0;
    if (rst) begin
      for (int j = 0; j < lat; j++) if (e - j >= 0) rv[k][e-j] = 1'b0;
      exp_vld[k] = 1'b0;
      exp_dat[k] = 32'h0;
    end else begin
      inr = int'(addr) < dep_of(k);
      old = inr ? mm[k][addr] : 32'h0;
      if (en) begin
        if (!wen) begin
          rv[k][e] = 1'b1;
          rd[k][e] = old;
        end else begin
          mg = inr ? tb_merge(old, din, be) : 32'h0;
          if (inr) mm[k][addr] = mg;
          if (thru_of(k)) begin
            rv[k][e] = 1'b1;
            rd[k][e] = mg;
          end
        end
      end
      idx = e - lat + 1;
      if (idx >= 0 && rv[k][idx]) begin
        exp_vld[k] = 1'b1;
        exp_dat[k] = rd[k][idx];
      end else begin
        exp_vld[k] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("vld%0d@%0d", k, e), 32'(obs_vld[k]), 32'(exp_vld[k]));
      chk($sformatf("dout%0d@%0d", k, e), obs_dat[k], exp_dat[k]);
    end
    e++;
  endtask

  task automatic req(input bit r, input bit en_i, input bit wen_i, input logic [3:0] be_i,
                     input logic [3:0] a_i, input logic [31:0] d_i);
    rst = r;  en = en_i;  wen = wen_i;  be = be_i;  addr = a_i;  din = d_i;
    tick();
  endtask

  task automatic idle();
    req(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;  en = 1'b0;  wen = 1'b0;  be = 4'h0;  addr = 4'h0;  din = 32'h0;
    for (int k = 0; k < 3; k++) for (int a = 0; a < 16; a++) mm[k][a] = 32'h0;

    repeat (3) req(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    chk("rst_a", {ia.dout[30:0], ia.dout_vld}, 32'h0);
    chk("rst_b", {ib.dout[30:0], ib.dout_vld}, 32'h0);
    chk("rst_c", {ic.dout[30:0], ic.dout_vld}, 32'h0);

    for (int a = 0; a < 16; a++)
      req(1'b0, 1'b1, 1'b1, 4'hF, 4'(a), (a < 3) ? 32'(10 + a) : $urandom);

    // Full write then read back with single-cycle latency.
    req(1'b0, 1'b1, 1'b1, 4'hF, 4'd3, 32'hDEADBEEF);
    req(1'b0, 1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    chk("t1_vld", 32'(ia.dout_vld), 32'h1);
    chk("t1_dout", ia.dout, 32'hDEADBEEF);

    // Lanes 0 and 2 only.
    req(1'b0, 1'b1, 1'b1, 4'b0101, 4'd3, 32'h11223344);
    req(1'b0, 1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    chk("t2_dout", ia.dout, 32'hDE22BE44);

    // Back-to-back reads through the three-stage instance.
    repeat (3) idle();
    req(1'b0, 1'b1, 1'b0, 4'h0, 4'd0, 32'h0);
    chk("t3_vld0", 32'(ic.dout_vld), 32'h0);
    req(1'b0, 1'b1, 1'b0, 4'h0, 4'd1, 32'h0);
    chk("t3_vld1", 32'(ic.dout_vld), 32'h0);
    req(1'b0, 1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
    chk("t3_a", {ic.dout[30:0], ic.dout_vld}, {31'hA, 1'b1});
    idle();
    chk("t3_b", {ic.dout[30:0], ic.dout_vld}, {31'hB, 1'b1});
    idle();
    chk("t3_c", {ic.dout[30:0], ic.dout_vld}, {31'hC, 1'b1});
    idle();
    chk("t3_hold", {ic.dout[30:0], ic.dout_vld}, {31'hC, 1'b0});

    // Out-of-range on the 10-deep instance.
    req(1'b0, 1'b1, 1'b1, 4'hF, 4'd12, 32'h5555AAAA);
    req(1'b0, 1'b1, 1'b0, 4'h0, 4'd12, 32'h0);
    idle();
    chk("t4_oor", {ib.dout[30:0], ib.dout_vld}, 32'h1);
    for (int a = 0; a < 10; a++) req(1'b0, 1'b1, 1'b0, 4'h0, 4'(a), 32'h0);
    repeat (3) idle();

    // Write-through of a partial write.
    req(1'b0, 1'b1, 1'b1, 4'hF, 4'd5, 32'hFFFFFFFF);
    repeat (3) idle();
    req(1'b0, 1'b1, 1'b1, 4'b0011, 4'd5, 32'h00000000);
    chk("t5_a_none", 32'(ia.dout_vld), 32'h0);
    idle();
    chk("t5_b_vld", 32'(ib.dout_vld), 32'h1);
    chk("t5_b_dout", ib.dout, 32'hFFFF0000);
    idle();
    chk("t5_c_none", 32'(ic.dout_vld), 32'h0);

    // Reset kills an in-flight read and ignores a write presented with it.
    repeat (3) idle();
    req(1'b0, 1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    req(1'b1, 1'b1, 1'b1, 4'hF, 4'd3, 32'h0);
    chk("t6_rst", {ib.dout[30:0], ib.dout_vld}, 32'h0);
    idle();
    chk("t6_flush", {ib.dout[30:0], ib.dout_vld}, 32'h0);
    req(1'b0, 1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    idle();
    chk("t6_keep", ib.dout, 32'hDE22BE44);

`ifdef SP_RAM_PARITY_EN
    req(1'b0, 1'b1, 1'b1, 4'hF, 4'd7, 32'h01020304);
    dut_a.mem_q[7][34] = ~dut_a.mem_q[7][34];
    req(1'b0, 1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
    chk("par_err", 32'(ia.parity_err), 32'h4);
    req(1'b0, 1'b1, 1'b1, 4'hF, 4'd7, 32'h01020304);
    req(1'b0, 1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
    chk("par_clean", 32'(ia.parity_err), 32'h0);
`endif

    for (int n = 0; n < 1500; n++)
      req(($urandom % 64) == 0, ($urandom % 4) != 0, 1'($urandom), 4'($urandom),
          4'($urandom), $urandom);
    repeat (4) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
